interrupt_controller: RTL and testbench

//   External interrupt controller in front of the csr unit: collects level-sensitive

---
 rtl/interrupt_controller.sv | 135 +++++++++++++
 tb/tb_interrupt_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// External interrupt controller: synchronizes level-sensitive device lines, latches them
// through per-source gateways, and offers claim/complete servicing over a tiny register bus.
module interrupt_controller #(
  parameter int NUM_SOURCES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_sources,
  output logic                   meip,
  input  logic                   bus_valid,
  input  logic                   bus_write,
  input  logic [3:0]             bus_address,
  input  logic [31:0]            bus_write_data,
  output logic [31:0]            bus_read_data,
  output logic                   bus_ready
);

  localparam int N = NUM_SOURCES;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_CLAIM   = 2'd2;

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [N-1:0] enable_q;
  logic [N-1:0] enable_d;
  logic [N-1:0] in_service_q;
  logic [N-1:0] in_service_d;
  logic         meip_q;
  logic         meip_d;
  logic         bus_ready_q;
  logic         bus_ready_d;
  logic [31:0]  bus_read_data_q;
  logic [31:0]  bus_read_data_d;

  logic         accept_s;
  logic [1:0]   reg_sel_s;
  logic [N-1:0] candidate_s;
  logic [4:0]   claim_id_s;
  logic [4:0]   complete_id_s;
  logic         unused_s;

  assign accept_s      = bus_valid && !bus_ready_q;
  assign reg_sel_s     = bus_address[3:2];
  assign candidate_s   = pending_q & enable_q;
  assign complete_id_s = bus_write_data[4:0];
  assign unused_s      = ^{bus_address[1:0], bus_write_data};

  // Lowest-index enabled pending source wins; scanning downward leaves the lowest one last.
  always_comb begin
    claim_id_s = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      claim_id_s = candidate_s[i] ? 5'(i + 1) : claim_id_s;
    end
  end

  // Gateway, register-file access, claim/complete and interrupt output next state.
  always_comb begin
    enable_d        = enable_q;
    in_service_d    = in_service_q;
    bus_ready_d     = accept_s;
    bus_read_data_d = 32'd0;
    meip_d          = |(pending_q & enable_q);
    for (int i = 0; i < N; i++) begin
      pending_d[i] = pending_q[i] | (sync2_q[i] & ~in_service_q[i]);
    end

    if (accept_s && !bus_write) begin
      case (reg_sel_s)
        REG_PENDING: bus_read_data_d = 32'(pending_q);
        REG_ENABLE:  bus_read_data_d = 32'(enable_q);
        REG_CLAIM: begin
          bus_read_data_d = 32'(claim_id_s);
          // Claim is applied after the gateway so it wins on the same edge.
          for (int i = 0; i < N; i++) begin
            if (claim_id_s == 5'(i + 1)) begin
              pending_d[i]    = 1'b0;
              in_service_d[i] = 1'b1;
            end else begin
              in_service_d[i] = in_service_q[i];
            end
          end
        end
        default: bus_read_data_d = 32'd0;
      endcase
    end else if (accept_s && bus_write) begin
      case (reg_sel_s)
        REG_ENABLE: enable_d = bus_write_data[N-1:0];
        REG_CLAIM: begin
          for (int i = 0; i < N; i++) begin
            if (complete_id_s == 5'(i + 1)) begin
              in_service_d[i] = 1'b0;
            end else begin
              in_service_d[i] = in_service_q[i];
            end
          end
        end
        default: enable_d = enable_q;
      endcase
    end else begin
      bus_read_data_d = 32'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      pending_q       <= '0;
      enable_q        <= '0;
      in_service_q    <= '0;
      meip_q          <= 1'b0;
      bus_ready_q     <= 1'b0;
      bus_read_data_q <= 32'd0;
    end else begin
      sync1_q         <= irq_sources;
      sync2_q         <= sync1_q;
      pending_q       <= pending_d;
      enable_q        <= enable_d;
      in_service_q    <= in_service_d;
      meip_q          <= meip_d;
      bus_ready_q     <= bus_ready_d;
      bus_read_data_q <= bus_read_data_d;
    end
  end

  assign meip          = meip_q;
  assign bus_ready     = bus_ready_q;
  assign bus_read_data = bus_read_data_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (NUM_SOURCES = 8).
module tb_interrupt_controller;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_sources;
  logic          meip;
  logic          bus_valid;
  logic          bus_write;
  logic [3:0]    bus_address;
  logic [31:0]   bus_write_data;
  logic [31:0]   bus_read_data;
  logic          bus_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        ack;
  logic        m_ack;
  logic        rdy_after;

  always #5 clk = ~clk;

  interrupt_controller #(.NUM_SOURCES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_sources   (irq_sources),
    .meip          (meip),
    .bus_valid     (bus_valid),
    .bus_write     (bus_write),
    .bus_address   (bus_address),
    .bus_write_data(bus_write_data),
    .bus_read_data (bus_read_data),
    .bus_ready     (bus_ready)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset       = 1'b1;
    irq_sources = '0;
    bus_valid   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus transaction; samples ack/data/meip just after the accepting edge and ready one edge later.
  task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus_valid      = 1'b1;
    bus_write      = wr;
    bus_address    = addr;
    bus_write_data = wdata;
    @(posedge clk);
    #1;
    ack   = bus_ready;
    rd    = bus_read_data;
    m_ack = meip;
    bus_valid = 1'b0;
    @(posedge clk);
    #1;
    rdy_after = bus_ready;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (meip !== 1'b0 || bus_ready !== 1'b0 || bus_read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: meip=%b ready=%b rdata=%h required 0/0/0", meip, bus_ready, bus_read_data);
    end
    for (int a = 0; a < 3; a++) begin
      xfer(1'b0, 4'(a * 4), 32'd0);
      checks++;
      if (ack !== 1'b1 || rdy_after !== 1'b0 || rd !== 32'd0) begin
        errors++;
        $display("FAIL reset_read_%0d: ack=%b ready_after=%b rdata=%h required 1/0/0", a, ack, rdy_after, rd);
      end
    end
  endtask

  task automatic test_regmap();
    apply_reset();
    xfer(1'b1, 4'h4, 32'hABCD_EF5A);
    xfer(1'b0, 4'h4, 32'd0);
    checks++;
    if (rd !== 32'h0000_005A) begin
      errors++;
      $display("FAIL enable_rw: got %h required %h", rd, 32'h0000_005A);
    end
    xfer(1'b1, 4'h0, 32'hFFFF_FFFF);
    xfer(1'b0, 4'h0, 32'd0);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL pending_ro: got %h required %h", rd, 32'd0);
    end
    xfer(1'b1, 4'hC, 32'h1234_5678);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_write_ack: got %b required 1", ack);
    end
    xfer(1'b0, 4'hD, 32'd0);
    checks++;
    if (ack !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_read: ack=%b rdata=%h required 1/0", ack, rd);
    end
  endtask

  task automatic test_latency_claim_complete();
    logic [3:0] seen;
    apply_reset();
    xfer(1'b1, 4'h4, 32'h0000_0004);
    @(negedge clk);
    irq_sources = 8'h04;
    for (int k = 0; k < 4; k++) begin
      wait_edges(1);
      seen[k] = meip;
    end
    checks++;
    if (seen !== 4'b1000) begin
      errors++;
      $display("FAIL meip_latency: meip after edges 4..1=%b required 1000", seen);
    end
    xfer(1'b0, 4'h8, 32'd0);
    checks++;
    if (rd !== 32'd3 || m_ack !== 1'b1 || meip !== 1'b0) begin
      errors++;
      $display("FAIL claim3: id=%0d meip_at_ack=%b meip_next=%b required 3/1/0", rd, m_ack, meip);
    end
    xfer(1'b1, 4'h8, 32'd3);
    wait_edges(1);
    checks++;
    if (meip !== 1'b1) begin
      errors++;
      $display("FAIL repend_meip: got %b required 1", meip);
    end
    xfer(1'b0, 4'h0, 32'd0);
    checks++;
    if (rd !== 32'h0000_0004) begin
      errors++;
      $display("FAIL repend_pending: got %h required %h", rd, 32'h0000_0004);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    xfer(1'b1, 4'h4, 32'h0000_00FF);
    @(negedge clk);
    irq_sources = 8'h22;
    wait_edges(5);
    checks++;
    if (meip !== 1'b1) begin
      errors++;
      $display("FAIL prio_meip: got %b required 1", meip);
    end
    xfer(1'b0, 4'h8, 32'd0);
    checks++;
    if (rd !== 32'd2) begin
      errors++;
      $display("FAIL prio_claim_first: got %0d required 2", rd);
    end
    xfer(1'b0, 4'h8, 32'd0);
    checks++;
    if (rd !== 32'd6) begin
      errors++;
      $display("FAIL prio_claim_second: got %0d required 6", rd);
    end
    xfer(1'b0, 4'h8, 32'd0);
    checks++;
    if (rd !== 32'd0 || meip !== 1'b0) begin
      errors++;
      $display("FAIL prio_claim_empty: id=%0d meip=%b required 0/0", rd, meip);
    end
    xfer(1'b0, 4'h0, 32'd0);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL prio_pending_clear: got %h required 0", rd);
    end
  endtask

  task automatic test_disabled();
    apply_reset();
    @(negedge clk);
    irq_sources = 8'h01;
    wait_edges(5);
    xfer(1'b0, 4'h0, 32'd0);
    checks++;
    if (rd !== 32'h0000_0001 || meip !== 1'b0) begin
      errors++;
      $display("FAIL disabled_pending: pending=%h meip=%b required 01/0", rd, meip);
    end
    xfer(1'b0, 4'h8, 32'd0);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL disabled_claim: got %0d required 0", rd);
    end
    xfer(1'b1, 4'h4, 32'h0000_0001);
    checks++;
    if (m_ack !== 1'b0 || meip !== 1'b1) begin
      errors++;
      $display("FAIL enable_late: meip_at_ack=%b meip_next=%b required 0/1", m_ack, meip);
    end
  endtask

  task automatic test_bad_complete();
    logic [31:0] ids [3];
    ids[0] = 32'd0;
    ids[1] = 32'd9;
    ids[2] = 32'd2;
    apply_reset();
    xfer(1'b1, 4'h4, 32'h0000_0001);
    @(negedge clk);
    irq_sources = 8'h01;
    wait_edges(5);
    xfer(1'b0, 4'h8, 32'd0);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL bad_setup_claim: got %0d required 1", rd);
    end
    for (int k = 0; k < 3; k++) begin
      xfer(1'b1, 4'h8, ids[k]);
      wait_edges(2);
      xfer(1'b0, 4'h0, 32'd0);
      checks++;
      if (ack !== 1'b1 || rd !== 32'd0) begin
        errors++;
        $display("FAIL bad_complete_id%0d: ack=%b pending=%h required 1/0", ids[k], ack, rd);
      end
    end
    xfer(1'b1, 4'h8, 32'd1);
    wait_edges(2);
    xfer(1'b0, 4'h0, 32'd0);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL good_complete: pending=%h required 01", rd);
    end
  endtask

  task automatic test_reset_mid_transaction();
    logic ready_seen;
    apply_reset();
    xfer(1'b1, 4'h4, 32'h0000_0001);
    @(negedge clk);
    irq_sources = 8'h01;
    wait_edges(5);
    @(negedge clk);
    bus_valid   = 1'b1;
    bus_write   = 1'b0;
    bus_address = 4'h8;
    #2;
    reset       = 1'b1;
    irq_sources = '0;
    ready_seen  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (bus_ready === 1'b1) ready_seen = 1'b1;
    end
    checks++;
    if (ready_seen !== 1'b0 || meip !== 1'b0 || bus_read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: ready_seen=%b meip=%b rdata=%h required 0/0/0", ready_seen, meip, bus_read_data);
    end
    bus_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    xfer(1'b0, 4'h4, 32'd0);
    checks++;
    if (ack !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_enable: ack=%b enable=%h required 1/0", ack, rd);
    end
    xfer(1'b0, 4'h0, 32'd0);
    checks++;
    if (ack !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_pending: ack=%b pending=%h required 1/0", ack, rd);
    end
  endtask

  initial begin
    reset          = 1'b1;
    irq_sources    = '0;
    bus_valid      = 1'b0;
    bus_write      = 1'b0;
    bus_address    = 4'h0;
    bus_write_data = 32'd0;
    test_reset();
    test_regmap();
    test_latency_claim_complete();
    test_priority();
    test_disabled();
    test_bad_complete();
    test_reset_mid_transaction();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
